// File: rtl/riscv_muldiv_pkg.sv
// Shared types and constants for the sequential RV32M execute unit.
// Included first; everything else imports riscv_muldiv_pkg::*.
package riscv_muldiv_pkg;

    localparam logic [6:0]  OPC_OP    = 7'b0110011;
    localparam logic [6:0]  F7_MULDIV = 7'b0000001;
    localparam logic [31:0] INT_MIN   = 32'h8000_0000;
    localparam logic [31:0] ALL1      = 32'hFFFF_FFFF;

    typedef enum logic [2:0] {
        F3_MUL    = 3'd0,
        F3_MULH   = 3'd1,
        F3_MULHSU = 3'd2,
        F3_MULHU  = 3'd3,
        F3_DIV    = 3'd4,
        F3_DIVU   = 3'd5,
        F3_REM    = 3'd6,
        F3_REMU   = 3'd7
    } funct3_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_DIV_PREP,
        S_DIV_SPECIAL
    } state_e;

    function automatic logic is_m(input logic [31:0] inst);
        return (inst[6:0] == OPC_OP) && (inst[31:25] == F7_MULDIV);
    endfunction

endpackage

// File: rtl/riscv_muldiv_seq_if.sv
// Issue/response bundle between the core and the muldiv unit.
// The core side is master; the execute unit is slave.
interface riscv_muldiv_seq_if;

    logic        valid_i;
    logic [31:0] inst_i;
    logic [31:0] operand_ra_i;
    logic [31:0] operand_rb_i;
    logic        kill_i;
    logic        busy_o;
    logic        ready_o;
    logic [31:0] result_o;

    modport master (
        output valid_i, inst_i, operand_ra_i, operand_rb_i, kill_i,
        input  busy_o, ready_o, result_o
    );

    modport slave (
        input  valid_i, inst_i, operand_ra_i, operand_rb_i, kill_i,
        output busy_o, ready_o, result_o
    );

endinterface

// File: rtl/riscv_div_iter.sv
// Unsigned restoring divider, one quotient bit per clock.
// done pulses for one cycle after the 32nd iteration edge.
module riscv_div_iter (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start,
    input  logic        kill,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    output logic        done,
    output logic [31:0] quotient,
    output logic [31:0] remainder
);

    logic [31:0] quo;
    logic [31:0] rem;
    logic [31:0] dvs;
    logic [4:0]  cnt;
    logic        run;
    logic [32:0] shifted;
    logic [32:0] diff;

    // rem < dvs always holds, so diff[32] is a clean borrow flag
    assign shifted = {rem, quo[31]};
    assign diff    = shifted - {1'b0, dvs};

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            quo  <= '0;
            rem  <= '0;
            dvs  <= '0;
            cnt  <= '0;
            run  <= 1'b0;
            done <= 1'b0;
        end else begin
            done <= 1'b0;
            if (kill) begin
                run <= 1'b0;
            end else if (start) begin
                quo <= dividend;
                rem <= '0;
                dvs <= divisor;
                cnt <= 5'd31;
                run <= 1'b1;
            end else if (run) begin
                rem <= diff[32] ? shifted[31:0] : diff[31:0];
                quo <= {quo[30:0], ~diff[32]};
                cnt <= cnt - 5'd1;
                if (cnt == 5'd0) begin
                    run  <= 1'b0;
                    done <= 1'b1;
                end
            end
        end
    end

    assign quotient  = quo;
    assign remainder = rem;

endmodule

// File: rtl/riscv_muldiv_seq.sv
// Sequential RV32M execute unit: multi-cycle multiply, iterative divide.
// One op in flight; result registered and flagged by a one-cycle ready_o.
module riscv_muldiv_seq
    import riscv_muldiv_pkg::*;
#(
    parameter int MUL_LATENCY = 2
) (
    input  logic               clk_i,
    input  logic               rst_i,
    riscv_muldiv_seq_if.slave  bus
);

    state_e      state;
    state_e      state_n;
    funct3_e     f3_in;
    funct3_e     f3_q;
    logic [31:0] ra_q;
    logic [31:0] rb_q;
    logic [31:0] spec_q;
    logic        q_neg_q;
    logic        r_neg_q;
    logic [1:0]  mul_cnt;
    logic        ready_q;
    logic [31:0] result_q;

    logic        accept;
    logic        complete;
    logic        div_op;
    logic        sgn_div;
    logic        rb_zero;
    logic        ovf;
    logic        special;
    logic [31:0] spec_in;
    logic [31:0] ra_abs;
    logic [31:0] rb_abs;
    logic [31:0] res_n;

    logic        div_done;
    logic [31:0] div_quo;
    logic [31:0] div_rem;

    logic        a_sx;
    logic        b_sx;
    logic [63:0] a64;
    logic [63:0] b64;
    logic [63:0] prod;

    assign f3_in   = funct3_e'(bus.inst_i[14:12]);
    assign accept  = bus.valid_i && is_m(bus.inst_i)
                     && (state == S_IDLE) && !bus.kill_i;
    assign div_op  = bus.inst_i[14];
    assign sgn_div = (f3_in == F3_DIV) || (f3_in == F3_REM);
    assign rb_zero = (bus.operand_rb_i == '0);
    assign ovf     = sgn_div && (bus.operand_ra_i == INT_MIN)
                     && (bus.operand_rb_i == ALL1);
    assign special = div_op && (rb_zero || ovf);

    // funct3[1] separates REM* from DIV* within the divide group
    always_comb begin
        spec_in = '0;
        unique case (1'b1)
            rb_zero && !bus.inst_i[13]: spec_in = ALL1;
            rb_zero &&  bus.inst_i[13]: spec_in = bus.operand_ra_i;
            !rb_zero && !bus.inst_i[13]: spec_in = INT_MIN;
            default:                    spec_in = '0;
        endcase
    end

    assign ra_abs = (sgn_div && bus.operand_ra_i[31])
                    ? -bus.operand_ra_i : bus.operand_ra_i;
    assign rb_abs = (sgn_div && bus.operand_rb_i[31])
                    ? -bus.operand_rb_i : bus.operand_rb_i;

    riscv_div_iter u_div (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .start     (accept && div_op && !special),
        .kill      (bus.kill_i),
        .dividend  (ra_abs),
        .divisor   (rb_abs),
        .done      (div_done),
        .quotient  (div_quo),
        .remainder (div_rem)
    );

    // low 64 bits of the extended product equal the 33x33 signed product
    assign a_sx = (f3_q != F3_MULHU) && ra_q[31];
    assign b_sx = ((f3_q == F3_MUL) || (f3_q == F3_MULH)) && rb_q[31];
    assign a64  = {{32{a_sx}}, ra_q};
    assign b64  = {{32{b_sx}}, rb_q};
    assign prod = a64 * b64;

    always_comb begin
        state_n  = state;
        complete = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (accept) begin
                    if (!div_op)      state_n = S_MUL;
                    else if (special) state_n = S_DIV_SPECIAL;
                    else              state_n = S_DIV_PREP;
                end
            end
            S_MUL: begin
                if (bus.kill_i) begin
                    state_n = S_IDLE;
                end else if (mul_cnt == 2'd0) begin
                    state_n  = S_IDLE;
                    complete = 1'b1;
                end
            end
            S_DIV_PREP: begin
                if (bus.kill_i) begin
                    state_n = S_IDLE;
                end else if (div_done) begin
                    state_n  = S_IDLE;
                    complete = 1'b1;
                end
            end
            S_DIV_SPECIAL: begin
                state_n  = S_IDLE;
                complete = !bus.kill_i;
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state <= S_IDLE;
        else       state <= state_n;
    end

    always_comb begin
        res_n = '0;
        if (state == S_DIV_SPECIAL) begin
            res_n = spec_q;
        end else begin
            unique case (f3_q)
                F3_MUL:                      res_n = prod[31:0];
                F3_MULH, F3_MULHSU, F3_MULHU: res_n = prod[63:32];
                F3_DIV, F3_DIVU:             res_n = q_neg_q ? -div_quo : div_quo;
                F3_REM, F3_REMU:             res_n = r_neg_q ? -div_rem : div_rem;
                default:                     res_n = '0;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            f3_q     <= F3_MUL;
            ra_q     <= '0;
            rb_q     <= '0;
            spec_q   <= '0;
            q_neg_q  <= 1'b0;
            r_neg_q  <= 1'b0;
            mul_cnt  <= '0;
            ready_q  <= 1'b0;
            result_q <= '0;
        end else begin
            ready_q <= complete;
            if (complete) result_q <= res_n;
            if (accept) begin
                f3_q    <= f3_in;
                ra_q    <= bus.operand_ra_i;
                rb_q    <= bus.operand_rb_i;
                spec_q  <= spec_in;
                q_neg_q <= sgn_div && (bus.operand_ra_i[31] ^ bus.operand_rb_i[31]);
                r_neg_q <= sgn_div && bus.operand_ra_i[31];
                mul_cnt <= 2'(MUL_LATENCY - 1);
            end else if ((state == S_MUL) && (mul_cnt != 2'd0)) begin
                mul_cnt <= mul_cnt - 2'd1;
            end
        end
    end

    assign bus.busy_o   = (state != S_IDLE);
    assign bus.ready_o  = ready_q;
    assign bus.result_o = result_q;

    a_no_busy_issue: assert property (
        @(posedge clk_i) disable iff (rst_i) !(bus.valid_i && bus.busy_o)
    );

endmodule

// File: tb/tb_riscv_muldiv_seq.sv
// Directed bench for riscv_muldiv_seq: hand-computed results and latencies.
// Inputs change #1 after a rising edge; outputs are sampled there too.
module tb_riscv_muldiv_seq;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    riscv_muldiv_seq_if bus ();

    riscv_muldiv_seq #(.MUL_LATENCY(2)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mk(input logic [2:0] f3);
        return {7'b0000001, 5'd2, 5'd1, f3, 5'd3, 7'b0110011};
    endfunction

    task automatic issue(input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] b);
        bus.inst_i       = mk(f3);
        bus.operand_ra_i = a;
        bus.operand_rb_i = b;
        bus.valid_i      = 1'b1;
        @(posedge clk);
        #1;
        bus.valid_i      = 1'b0;
        bus.operand_ra_i = 32'hDEAD_BEEF;
        bus.operand_rb_i = 32'h1234_5678;
    endtask

    task automatic expect_done(input string tag, input int lat,
                               input logic [31:0] exp);
        int n;
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!bus.ready_o && n < 60);
        chk({tag, "_lat"}, 32'(n), 32'(lat));
        chk(tag, bus.result_o, exp);
    endtask

    task automatic quiet(input string tag, input int cycles);
        int pulses;
        pulses = 0;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk);
            #1;
            if (bus.ready_o) pulses++;
        end
        chk(tag, 32'(pulses), 32'd0);
    endtask

    initial begin
        bus.valid_i      = 1'b0;
        bus.inst_i       = '0;
        bus.operand_ra_i = '0;
        bus.operand_rb_i = '0;
        bus.kill_i       = 1'b0;

        #12;
        chk("rst_busy", {31'd0, bus.busy_o}, 32'd0);
        chk("rst_ready", {31'd0, bus.ready_o}, 32'd0);
        chk("rst_result", bus.result_o, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // ADD (funct7=0) must be ignored
        bus.inst_i  = {7'b0000000, 5'd2, 5'd1, 3'd0, 5'd3, 7'b0110011};
        bus.valid_i = 1'b1;
        @(posedge clk);
        #1;
        bus.valid_i = 1'b0;
        chk("nonm_busy", {31'd0, bus.busy_o}, 32'd0);

        issue(3'd0, 32'd7, 32'hFFFF_FFFD);
        chk("mul_busy", {31'd0, bus.busy_o}, 32'd1);
        expect_done("mul", 2, 32'hFFFF_FFEB);
        @(posedge clk);
        #1;
        chk("mul_pulse", {31'd0, bus.ready_o}, 32'd0);
        chk("mul_hold", bus.result_o, 32'hFFFF_FFEB);

        issue(3'd1, 32'h8000_0000, 32'h8000_0000);
        expect_done("mulh", 2, 32'h4000_0000);
        issue(3'd2, 32'h8000_0000, 32'h8000_0000);
        expect_done("mulhsu", 2, 32'hC000_0000);
        issue(3'd3, 32'h8000_0000, 32'h8000_0000);
        expect_done("mulhu", 2, 32'h4000_0000);

        issue(3'd4, 32'hFFFF_FFF9, 32'd2);
        expect_done("div", 33, 32'hFFFF_FFFD);
        issue(3'd6, 32'hFFFF_FFF9, 32'd2);
        expect_done("rem", 33, 32'hFFFF_FFFF);
        issue(3'd5, 32'd100, 32'd7);
        expect_done("divu", 33, 32'd14);
        issue(3'd7, 32'd100, 32'd7);
        expect_done("remu", 33, 32'd2);
        issue(3'd4, 32'h8000_0000, 32'd2);
        expect_done("div_min2", 33, 32'hC000_0000);

        issue(3'd5, 32'd123, 32'd0);
        expect_done("divu_z", 1, 32'hFFFF_FFFF);
        issue(3'd6, 32'd5, 32'd0);
        expect_done("rem_z", 1, 32'd5);
        issue(3'd4, 32'h8000_0000, 32'hFFFF_FFFF);
        expect_done("div_ovf", 1, 32'h8000_0000);
        issue(3'd6, 32'h8000_0000, 32'hFFFF_FFFF);
        expect_done("rem_ovf", 1, 32'd0);

        issue(3'd4, 32'd100, 32'd3);
        for (int i = 0; i < 9; i++) begin
            @(posedge clk);
            #1;
        end
        bus.kill_i = 1'b1;
        @(posedge clk);
        #1;
        bus.kill_i = 1'b0;
        chk("kill_busy", {31'd0, bus.busy_o}, 32'd0);
        chk("kill_ready", {31'd0, bus.ready_o}, 32'd0);
        chk("kill_result", bus.result_o, 32'd0);
        issue(3'd0, 32'd3, 32'd4);
        expect_done("mul_after_kill", 2, 32'd12);
        issue(3'd5, 32'd100, 32'd7);
        chk("b2b_busy", {31'd0, bus.busy_o}, 32'd1);
        expect_done("b2b_divu", 33, 32'd14);
        quiet("kill_stale", 30);

        issue(3'd4, 32'd1000, 32'd7);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
        end
        rst = 1'b1;
        #1;
        chk("mid_rst_busy", {31'd0, bus.busy_o}, 32'd0);
        chk("mid_rst_ready", {31'd0, bus.ready_o}, 32'd0);
        chk("mid_rst_result", bus.result_o, 32'd0);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        quiet("rst_stale", 40);
        chk("rst_idle", {31'd0, bus.busy_o}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
